counter_4bit: RTL and testbench



---
 rtl/counter_4bit_pkg.sv | 14 +
 rtl/counter_4bit.sv | 62 ++++++
 tb/tb_counter_4bit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/counter_4bit_pkg.sv
// -----------------------------------------------------------------------------
// counter_4bit_pkg
// Shared definitions for the free-running counter and anything that observes it.
//   DEFAULT_WIDTH : default counter width in bits (4)
//   count_t       : count type at the default width, so instantiating logic and
//                   monitors size their count wires identically
// -----------------------------------------------------------------------------
package counter_4bit_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage : counter_4bit_pkg

// File: rtl/counter_4bit.sv
// -----------------------------------------------------------------------------
// counter_4bit
// Free-running synchronous up-counter. Increments once per rising CLK edge and
// returns to zero on the edge after it holds MAX. No enable, load or carry.
//
// Parameters
//   WIDTH : counter width in bits (default 4)
//   MAX   : terminal count, legal range 1 .. 2**WIDTH-1 (default 2**WIDTH-1)
//
// Ports
//   CLK   in  1      sole clock, rising-edge active
//   RST_X in  1      synchronous active-low reset, priority over counting
//   CNT   out WIDTH  current count, driven straight from a register
// -----------------------------------------------------------------------------
module counter_4bit
   import counter_4bit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int MAX   = 2**WIDTH - 1
) (
   input  logic             CLK,
   input  logic             RST_X,
   output logic [WIDTH-1:0] CNT
);

   // Reject an out-of-range terminal count while elaborating.
   generate
      if ((MAX < 1) || (MAX > (2**WIDTH - 1))) begin : g_bad_max
         $error("counter_4bit: MAX=%0d outside 1..%0d", MAX, 2**WIDTH - 1);
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

   logic [WIDTH-1:0] r_cnt;
   logic             w_at_max;
   logic [WIDTH-1:0] w_cnt_next;

   // The explicit compare also covers the default MAX, where it coincides
   // with natural modulo-2**WIDTH overflow of the incrementer.
   assign w_at_max   = (r_cnt == MAX_C);
   assign w_cnt_next = w_at_max ? '0 : (r_cnt + ONE_C);

   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

   assign CNT = r_cnt;

`ifndef SYNTHESIS
   // The count must never leave 0..MAX once reset has been applied.
   a_cnt_in_range : assert property (@(posedge CLK) disable iff (!RST_X)
                                     (r_cnt <= MAX_C))
      else $error("counter_4bit: CNT=%0d exceeds MAX=%0d", r_cnt, MAX);
`endif

endmodule : counter_4bit

// File: tb/tb_counter_4bit.sv
// -----------------------------------------------------------------------------
// tb_counter_4bit
// Drives two counters from one clock and reset: the default 4-bit / MAX=15
// instance and a 4-bit / MAX=9 instance. A vector table covers reset, count-up,
// the MAX=9 wrap and reset on the terminal count; hand sequences cover the
// 17-edge default wrap and a mid-count reset; a randomized phase compares both
// counters against a modulo-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_counter_4bit;
   import counter_4bit_pkg::*;

   localparam int MAX9 = 9;

   logic   clk;
   logic   rst_x;
   count_t cnt_def;
   count_t cnt_m9;

   int n_checks;
   int n_fail;
   int n_tx;

   // Reference model state: plain modulo arithmetic on integers.
   int m_def;
   int m_m9;

   typedef struct {
      logic rst_x;
      int   exp_def;
      int   exp_m9;
   } vec_t;

   localparam int NV = 20;
   vec_t vec [NV];

   counter_4bit u_dut_def (
      .CLK   (clk),
      .RST_X (rst_x),
      .CNT   (cnt_def)
   );

   counter_4bit #(
      .WIDTH (4),
      .MAX   (MAX9)
   ) u_dut_m9 (
      .CLK   (clk),
      .RST_X (rst_x),
      .CNT   (cnt_m9)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock edge with the given reset level; outputs are sampled 1 ns after
   // the edge. The reference model advances on the same edge.
   task automatic step(input logic r);
      rst_x = r;
      @(posedge clk);
      if (!r) begin
         m_def = 0;
         m_m9  = 0;
      end else begin
         m_def = (m_def + 1) % 16;
         m_m9  = (m_m9 + 1) % (MAX9 + 1);
      end
      #1;
      n_tx++;
      $display("tx %0d rst_x=%b cnt_def=%0d cnt_m9=%0d", n_tx, r, cnt_def, cnt_m9);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      n_tx     = 0;
      m_def    = 0;
      m_m9     = 0;
      rst_x    = 1'b0;

      // Reset two edges, release for 10 (MAX=9 wraps at the 10th), two more
      // for the MAX=9 1,2 tail, three more to reach 15, then reset on 15.
      vec[0]  = '{1'b0, 0, 0};
      vec[1]  = '{1'b0, 0, 0};
      for (int i = 1; i <= 10; i++) vec[1 + i] = '{1'b1, i, i % 10};
      vec[12] = '{1'b1, 11, 1};
      vec[13] = '{1'b1, 12, 2};
      vec[14] = '{1'b1, 13, 3};
      vec[15] = '{1'b1, 14, 4};
      vec[16] = '{1'b1, 15, 5};
      vec[17] = '{1'b0, 0, 0};
      vec[18] = '{1'b1, 1, 1};
      vec[19] = '{1'b1, 2, 2};

      for (int i = 0; i < NV; i++) begin
         step(vec[i].rst_x);
         check($sformatf("vec%0d_def", i), int'(cnt_def), vec[i].exp_def);
         check($sformatf("vec%0d_m9", i), int'(cnt_m9), vec[i].exp_m9);
      end

      // Default wrap: reset then 17 edges -> 1..15, 0, 1.
      step(1'b0);
      check("wrap_rst_def", int'(cnt_def), 0);
      for (int i = 1; i <= 17; i++) begin
         step(1'b1);
         check($sformatf("wrap%0d_def", i), int'(cnt_def), i % 16);
         check($sformatf("wrap%0d_m9", i), int'(cnt_m9), i % 10);
      end

      // Mid-count reset: advance from 1 to 7, reset one edge, release.
      for (int v = 2; v <= 7; v++) begin
         step(1'b1);
         check($sformatf("mid_up%0d", v), int'(cnt_def), v);
      end
      step(1'b0);
      check("mid_rst_def", int'(cnt_def), 0);
      check("mid_rst_m9", int'(cnt_m9), 0);
      for (int v = 1; v <= 3; v++) begin
         step(1'b1);
         check($sformatf("mid_after%0d", v), int'(cnt_def), v);
      end

      // Randomized reset pattern against the reference model.
      for (int i = 0; i < 200; i++) begin
         step(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
         check($sformatf("rnd%0d_def", i), int'(cnt_def), m_def);
         check($sformatf("rnd%0d_m9", i), int'(cnt_m9), m_m9);
         if (int'(cnt_m9) > MAX9) begin
            check($sformatf("rnd%0d_m9_range", i), int'(cnt_m9), m_m9);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_counter_4bit
